hazard_unit: RTL and testbench

Hazard and forwarding controller for the five-stage MIPS pipeline. It drives the `clr` input of the issue-execute pipeline register, the fetch/decode stall and flush controls, and the EX-stage operand forwarding selects. It also tracks the multi-cycle HI/LO multiply/divide unit so that dependent `mfhi`/`mflo` instructions wait in decode.

---
 rtl/mips_pipe_pkg.sv | 20 ++
 rtl/hazard_fwd_sel.sv | 25 ++
 rtl/hazard_unit.sv | 132 +++++++++++++
 tb/tb_hazard_unit.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the MIPS pipeline hazard logic: forwarding selects,
// HI/LO tracker state encoding and the register-match helper.
package mips_pipe_pkg;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   typedef enum logic {
      ST_RUN     = 1'b0,
      ST_MD_BUSY = 1'b1
   } md_state_e;

   // $zero is hard-wired, so it never produces a dependency.
   function automatic logic reg_match(input logic [4:0] src, input logic [4:0] dst,
                                      input logic wr_en);
      return wr_en && (src != 5'd0) && (src == dst);
   endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// Forwarding selector for one EX operand: MEM ALU result beats WB result,
// which beats the register file.
module hazard_fwd_sel
   import mips_pipe_pkg::*;
(
   input  logic [4:0] src_i,
   input  logic       mem_wr_i,
   input  logic       mem_load_i,
   input  logic [4:0] dst_mem_i,
   input  logic       wb_wr_i,
   input  logic [4:0] dst_wb_i,
   output logic [1:0] fwd_o
);

   always_comb begin
      fwd_o = FWD_RF;
      // A load in MEM has no data yet; fall through so an older WB write can still win.
      if (reg_match(src_i, dst_mem_i, mem_wr_i) && !mem_load_i) begin
         fwd_o = FWD_MEM;
      end else if (reg_match(src_i, dst_wb_i, wb_wr_i)) begin
         fwd_o = FWD_WB;
      end
   end

endmodule

// File: rtl/hazard_unit.sv
// Hazard and forwarding controller for the five-stage MIPS pipeline, including
// the HI/LO busy tracker that holds mfhi/mflo in decode.
module hazard_unit
   import mips_pipe_pkg::*;
#(
   parameter int unsigned MULDIV_LAT = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] rs_id_i,
   input  logic [4:0] rt_id_i,
   input  logic       rs_used_id_i,
   input  logic       rt_used_id_i,
   input  logic       branch_id_i,
   input  logic       branch_taken_id_i,
   input  logic       hilo_rd_id_i,
   input  logic       valid_ex_i,
   input  logic       reg_wr_ex_i,
   input  logic       mem_to_reg_ex_i,
   input  logic       muldiv_ex_i,
   input  logic [4:0] dst_ex_i,
   input  logic [4:0] rs_ex_i,
   input  logic [4:0] rt_ex_i,
   input  logic       valid_mem_i,
   input  logic       reg_wr_mem_i,
   input  logic       mem_to_reg_mem_i,
   input  logic [4:0] dst_mem_i,
   input  logic       reg_wr_wb_i,
   input  logic [4:0] dst_wb_i,
   output logic       stall_if_o,
   output logic       stall_id_o,
   output logic       clr_id_o,
   output logic       clr_ex_o,
   output logic [1:0] fwd_a_ex_o,
   output logic [1:0] fwd_b_ex_o,
   output logic       muldiv_busy_o
);

   localparam int unsigned CntW = $clog2(MULDIV_LAT + 1);

   md_state_e       state_q, state_d;
   logic [CntW-1:0] md_cnt_q, md_cnt_d;

   logic ex_wr, mem_wr, md_start;
   logic ex_hit, mem_load_hit;
   logic load_use, br_dep, hilo_dep, stall;

   assign ex_wr    = valid_ex_i & reg_wr_ex_i;
   assign mem_wr   = valid_mem_i & reg_wr_mem_i;
   assign md_start = valid_ex_i & muldiv_ex_i;

   always_comb begin
      ex_hit = (rs_used_id_i && reg_match(rs_id_i, dst_ex_i, ex_wr)) ||
               (rt_used_id_i && reg_match(rt_id_i, dst_ex_i, ex_wr));
      mem_load_hit = mem_to_reg_mem_i &&
                     ((rs_used_id_i && reg_match(rs_id_i, dst_mem_i, mem_wr)) ||
                      (rt_used_id_i && reg_match(rt_id_i, dst_mem_i, mem_wr)));
      load_use = mem_to_reg_ex_i && ex_hit;
      br_dep   = branch_id_i && (ex_hit || mem_load_hit);
      hilo_dep = hilo_rd_id_i && (muldiv_busy_o || md_start);
      stall    = load_use || br_dep || hilo_dep;
   end

   assign stall_if_o = stall;
   assign stall_id_o = stall;
   assign clr_ex_o   = stall;
   // An unresolved branch must not flush the instruction behind it.
   assign clr_id_o   = branch_taken_id_i & ~stall;

   hazard_fwd_sel u_fwd_a (
      .src_i      (rs_ex_i),
      .mem_wr_i   (mem_wr),
      .mem_load_i (mem_to_reg_mem_i),
      .dst_mem_i  (dst_mem_i),
      .wb_wr_i    (reg_wr_wb_i),
      .dst_wb_i   (dst_wb_i),
      .fwd_o      (fwd_a_ex_o)
   );

   hazard_fwd_sel u_fwd_b (
      .src_i      (rt_ex_i),
      .mem_wr_i   (mem_wr),
      .mem_load_i (mem_to_reg_mem_i),
      .dst_mem_i  (dst_mem_i),
      .wb_wr_i    (reg_wr_wb_i),
      .dst_wb_i   (dst_wb_i),
      .fwd_o      (fwd_b_ex_o)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_RUN;
         md_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         md_cnt_q <= md_cnt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      md_cnt_d = md_cnt_q;
      unique case (state_q)
         ST_RUN: begin
            if (md_start) begin
               state_d  = ST_MD_BUSY;
               md_cnt_d = CntW'(MULDIV_LAT);
            end
         end
         ST_MD_BUSY: begin
            // A back-to-back mul/div should be blocked by hilo_dep; restart the window if not.
            if (md_start) begin
               md_cnt_d = CntW'(MULDIV_LAT);
            end else if (md_cnt_q == CntW'(1)) begin
               state_d  = ST_RUN;
               md_cnt_d = '0;
            end else begin
               md_cnt_d = md_cnt_q - CntW'(1);
            end
         end
         default: begin
            state_d  = ST_RUN;
            md_cnt_d = '0;
         end
      endcase
   end

   always_comb begin
      muldiv_busy_o = (state_q == ST_MD_BUSY);
   end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: hand-checked scenarios plus a per-cycle
// comparison against a behavioural model of the hazard rules.
module tb_hazard_unit;

   localparam int unsigned LAT = 4;

   logic       clk, reset;
   logic [4:0] rs_id, rt_id, dst_ex, rs_ex, rt_ex, dst_mem, dst_wb;
   logic       rs_used, rt_used, branch, taken, hilo_rd;
   logic       valid_ex, reg_wr_ex, m2r_ex, muldiv_ex;
   logic       valid_mem, reg_wr_mem, m2r_mem, reg_wr_wb;
   logic       stall_if, stall_id, clr_id, clr_ex, busy;
   logic [1:0] fwd_a, fwd_b;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int busy_last = -1;

   hazard_unit #(.MULDIV_LAT(LAT)) dut (
      .clk               (clk),
      .reset             (reset),
      .rs_id_i           (rs_id),
      .rt_id_i           (rt_id),
      .rs_used_id_i      (rs_used),
      .rt_used_id_i      (rt_used),
      .branch_id_i       (branch),
      .branch_taken_id_i (taken),
      .hilo_rd_id_i      (hilo_rd),
      .valid_ex_i        (valid_ex),
      .reg_wr_ex_i       (reg_wr_ex),
      .mem_to_reg_ex_i   (m2r_ex),
      .muldiv_ex_i       (muldiv_ex),
      .dst_ex_i          (dst_ex),
      .rs_ex_i           (rs_ex),
      .rt_ex_i           (rt_ex),
      .valid_mem_i       (valid_mem),
      .reg_wr_mem_i      (reg_wr_mem),
      .mem_to_reg_mem_i  (m2r_mem),
      .dst_mem_i         (dst_mem),
      .reg_wr_wb_i       (reg_wr_wb),
      .dst_wb_i          (dst_wb),
      .stall_if_o        (stall_if),
      .stall_id_o        (stall_id),
      .clr_id_o          (clr_id),
      .clr_ex_o          (clr_ex),
      .fwd_a_ex_o        (fwd_a),
      .fwd_b_ex_o        (fwd_b),
      .muldiv_busy_o     (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0b, expected %0b (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: HI/LO busy is "the current cycle falls inside the last mul/div's window".
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         busy_last = -1;
      end else begin
         if (valid_ex && muldiv_ex) busy_last = cyc + LAT;
         cyc++;
      end
   end

   function automatic bit src_dep(input logic [4:0] r, input logic used, input logic [4:0] d,
                                  input logic en);
      return used && en && r != 0 && r == d;
   endfunction

   function automatic logic [1:0] fwd_model(input logic [4:0] r);
      if (r == 0) return 2'b00;
      if (valid_mem && reg_wr_mem && !m2r_mem && dst_mem == r) return 2'b10;
      if (reg_wr_wb && dst_wb == r) return 2'b01;
      return 2'b00;
   endfunction

   always @(negedge clk) begin
      bit exp_busy, ex_dep, mem_ld_dep, exp_stall;
      exp_busy   = (cyc <= busy_last);
      ex_dep     = src_dep(rs_id, rs_used, dst_ex, valid_ex && reg_wr_ex) ||
                   src_dep(rt_id, rt_used, dst_ex, valid_ex && reg_wr_ex);
      mem_ld_dep = src_dep(rs_id, rs_used, dst_mem, valid_mem && reg_wr_mem && m2r_mem) ||
                   src_dep(rt_id, rt_used, dst_mem, valid_mem && reg_wr_mem && m2r_mem);
      exp_stall  = (m2r_ex && ex_dep) || (branch && (ex_dep || mem_ld_dep)) ||
                   (hilo_rd && (exp_busy || (valid_ex && muldiv_ex)));
      check("model_busy", {1'b0, busy}, {1'b0, exp_busy});
      check("model_stall_if", {1'b0, stall_if}, {1'b0, exp_stall});
      check("model_stall_id", {1'b0, stall_id}, {1'b0, exp_stall});
      check("model_clr_ex", {1'b0, clr_ex}, {1'b0, exp_stall});
      check("model_clr_id", {1'b0, clr_id}, {1'b0, taken && !exp_stall});
      check("model_fwd_a", fwd_a, fwd_model(rs_ex));
      check("model_fwd_b", fwd_b, fwd_model(rt_ex));
   end

   task automatic idle();
      rs_id = 0; rt_id = 0; rs_used = 0; rt_used = 0; branch = 0; taken = 0; hilo_rd = 0;
      valid_ex = 0; reg_wr_ex = 0; m2r_ex = 0; muldiv_ex = 0; dst_ex = 0; rs_ex = 0; rt_ex = 0;
      valid_mem = 0; reg_wr_mem = 0; m2r_mem = 0; dst_mem = 0; reg_wr_wb = 0; dst_wb = 0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_stall(input string name, input logic exp);
      check({name, "_stall_if"}, {1'b0, stall_if}, {1'b0, exp});
      check({name, "_stall_id"}, {1'b0, stall_id}, {1'b0, exp});
      check({name, "_clr_ex"}, {1'b0, clr_ex}, {1'b0, exp});
   endtask

   initial begin
      reset = 1'b0;
      idle();
      #2;
      check_stall("reset", 1'b0);
      check("reset_busy", {1'b0, busy}, 2'b00);
      check("reset_clr_id", {1'b0, clr_id}, 2'b00);
      check("reset_fwd_a", fwd_a, 2'b00);
      check("reset_fwd_b", fwd_b, 2'b00);
      step();
      reset = 1'b1;
      step();

      // Load-use: lw $5 in EX, add with rs=5 in ID
      valid_ex = 1; reg_wr_ex = 1; m2r_ex = 1; dst_ex = 5;
      rs_id = 5; rs_used = 1; rt_id = 6; rt_used = 1;
      #1 check_stall("lu_t", 1'b1);
      step();
      idle();
      valid_mem = 1; reg_wr_mem = 1; m2r_mem = 1; dst_mem = 5;
      rs_id = 5; rs_used = 1; rt_id = 6; rt_used = 1;
      #1 check_stall("lu_t1", 1'b0);
      step();
      idle();
      reg_wr_wb = 1; dst_wb = 5; rs_ex = 5; rt_ex = 6;
      #1 check("lu_fwd_a_wb", fwd_a, 2'b01);
      check("lu_fwd_b_rf", fwd_b, 2'b00);
      step();

      // Forwarding priority
      idle();
      valid_mem = 1; reg_wr_mem = 1; dst_mem = 7; reg_wr_wb = 1; dst_wb = 7;
      rs_ex = 7; rt_ex = 7;
      #1 check("fp_a_mem", fwd_a, 2'b10);
      check("fp_b_mem", fwd_b, 2'b10);
      step();
      m2r_mem = 1;
      #1 check("fp_load_falls_to_wb", fwd_a, 2'b01);
      step();
      m2r_mem = 0; valid_mem = 0;
      #1 check("fp_mem_invalid", fwd_b, 2'b01);
      step();
      idle();
      valid_mem = 1; reg_wr_mem = 1; reg_wr_wb = 1;
      #1 check("fp_zero_a", fwd_a, 2'b00);
      check("fp_zero_b", fwd_b, 2'b00);
      step();

      // Stall vs flush on a branch dependency
      idle();
      branch = 1; taken = 1; rs_id = 3; rs_used = 1;
      valid_ex = 1; reg_wr_ex = 1; dst_ex = 3;
      #1 check_stall("bd", 1'b1);
      check("bd_no_flush", {1'b0, clr_id}, 2'b00);
      step();
      valid_ex = 0; reg_wr_ex = 0; dst_ex = 0;
      #1 check_stall("bd_gone", 1'b0);
      check("bd_flush", {1'b0, clr_id}, 2'b01);
      step();
      // Branch waiting on a load in MEM; an ALU op in MEM is forwarded instead
      idle();
      branch = 1; rt_id = 9; rt_used = 1;
      valid_mem = 1; reg_wr_mem = 1; m2r_mem = 1; dst_mem = 9;
      #1 check_stall("bd_mem_load", 1'b1);
      step();
      m2r_mem = 0;
      #1 check_stall("bd_mem_alu", 1'b0);
      step();
      // Load-use with a taken jump: stall wins
      idle();
      taken = 1; valid_ex = 1; reg_wr_ex = 1; m2r_ex = 1; dst_ex = 4; rt_id = 4; rt_used = 1;
      #1 check_stall("lu_taken", 1'b1);
      check("lu_taken_no_flush", {1'b0, clr_id}, 2'b00);
      rt_used = 0;
      #1 check_stall("lu_unused_src", 1'b0);
      dst_ex = 0; rt_id = 0; rt_used = 1;
      #1 check_stall("lu_reg0", 1'b0);
      step();

      // Mul/div with dependent mfhi
      idle();
      valid_ex = 1; muldiv_ex = 1; hilo_rd = 1;
      #1 check_stall("md_t", 1'b1);
      check("md_t_busy", {1'b0, busy}, 2'b00);
      for (int k = 1; k <= int'(LAT); k++) begin
         step();
         valid_ex = 0; muldiv_ex = 0;
         #1 check_stall("md_hold", 1'b1);
         check("md_busy", {1'b0, busy}, 2'b01);
      end
      step();
      #1 check_stall("md_done", 1'b0);
      check("md_done_busy", {1'b0, busy}, 2'b00);
      step();

      // Reset in the middle of a busy window
      idle();
      valid_ex = 1; muldiv_ex = 1;
      step();
      idle();
      step();
      #1 check("rm_busy_before", {1'b0, busy}, 2'b01);
      reset = 1'b0;
      #1 check("rm_busy_async", {1'b0, busy}, 2'b00);
      step();
      reset = 1'b1;
      hilo_rd = 1;
      #1 check_stall("rm_after", 1'b0);
      step();
      #1 check("rm_busy_after", {1'b0, busy}, 2'b00);
      check_stall("rm_after2", 1'b0);
      step();
      idle();
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
